// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
  parameter int DW = 32
) ();
  logic          dm_req;
  logic          dm_we;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: variable-latency data-memory access, branch resolution,
// upstream stall generation and the MEM/WB pipeline register.
module mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    WB_in,
  input  logic [2:0]    MEM_in,
  input  logic [DW-1:0] add_in,
  input  logic [DW-1:0] alu_in,
  input  logic [DW-1:0] RD2_in,
  input  logic [RW-1:0] WN_in,
  input  logic          z_in,
  mem_stage_if.master   dm,
  output logic          stall,
  output logic          pc_src,
  output logic [DW-1:0] br_target,
  output logic [1:0]    WB_out,
  output logic [DW-1:0] rdata_out,
  output logic [DW-1:0] alu_out,
  output logic [RW-1:0] WN_out,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_n;
  logic          dm_req_q;
  logic [DW-1:0] rd_buf;

  logic mem_read, mem_write, access, illegal, legal;
  logic stall_c, err_set, capture, ld_full, ld_bubble, use_buf;

  assign mem_read  = MEM_in[1];
  assign mem_write = MEM_in[0];
  assign access    = mem_read ^ mem_write;
  assign illegal   = (mem_read & mem_write) | (access & (alu_in[1:0] != 2'b00));
  assign legal     = access & ~illegal;

  always_comb begin
    state_n   = state;
    stall_c   = 1'b0;
    err_set   = 1'b0;
    capture   = 1'b0;
    ld_full   = 1'b0;
    ld_bubble = 1'b0;
    use_buf   = 1'b0;
    case (state)
      IDLE: begin
        if (illegal) begin
          err_set   = 1'b1;
          ld_bubble = 1'b1;
        end else if (legal) begin
          stall_c   = 1'b1;
          ld_bubble = 1'b1;
          state_n   = ACCESS;
        end else begin
          ld_full = 1'b1;
        end
      end
      ACCESS: begin
        stall_c   = 1'b1;
        ld_bubble = 1'b1;
        if (dm.dm_ack) begin
          capture = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        ld_full = 1'b1;
        use_buf = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Gating with rst keeps stall low during reset even while a legal access is still presented.
  assign stall     = rst & stall_c;
  assign pc_src    = MEM_in[2] & z_in & (state == IDLE);
  assign br_target = add_in;

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_req_q & mem_write;
  assign dm.dm_addr  = dm_req_q ? alu_in : '0;
  assign dm.dm_wdata = dm_req_q ? RD2_in : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dm_req_q  <= 1'b0;
      rd_buf    <= '0;
      err       <= 1'b0;
      WB_out    <= '0;
      rdata_out <= '0;
      alu_out   <= '0;
      WN_out    <= '0;
    end else begin
      state    <= state_n;
      dm_req_q <= (state_n == ACCESS);
      if (err_set) err <= 1'b1;
      if (capture) rd_buf <= mem_write ? '0 : dm.dm_rdata;
      if (ld_full) begin
        WB_out    <= WB_in;
        rdata_out <= use_buf ? rd_buf : '0;
        alu_out   <= alu_in;
        WN_out    <= WN_in;
      end else if (ld_bubble) begin
        WB_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset corner case, randomized instruction stream.
module tb_mem_stage;

  logic        clk, rst;
  logic [1:0]  WB_in;
  logic [2:0]  MEM_in;
  logic [31:0] add_in, alu_in, RD2_in;
  logic [4:0]  WN_in;
  logic        z_in;
  logic        stall, pc_src;
  logic [31:0] br_target, rdata_out, alu_out;
  logic [1:0]  WB_out;
  logic [4:0]  WN_out;
  logic        err;

  mem_stage_if #(.DW(32)) dmi ();

  mem_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .WB_in(WB_in), .MEM_in(MEM_in), .add_in(add_in),
    .alu_in(alu_in), .RD2_in(RD2_in), .WN_in(WN_in), .z_in(z_in), .dm(dmi),
    .stall(stall), .pc_src(pc_src), .br_target(br_target), .WB_out(WB_out),
    .rdata_out(rdata_out), .alu_out(alu_out), .WN_out(WN_out), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Architectural view of the MEM/WB register and error flag
  logic [1:0]  m_wb;
  logic [31:0] m_rdata, m_alu;
  logic [4:0]  m_wn;
  logic        m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_wb = '0; m_rdata = '0; m_alu = '0; m_wn = '0; m_err = 1'b0;
  endtask

  // Presents one instruction just after a rising edge, holds it for its whole
  // occupancy, plays memory with the given ack delay, and checks every cycle.
  task automatic run_instr(input logic [1:0] wb, input logic [2:0] mem, input logic [31:0] add,
                           input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wn,
                           input logic z, input int unsigned dly, input logic [31:0] rdata,
                           input logic spur);
    logic rd, wr, acc, illegal, legal, req_exp;
    int unsigned n;
    rd      = mem[1];
    wr      = mem[0];
    acc     = rd ^ wr;
    illegal = (rd & wr) | (acc & (alu[1:0] != 2'b00));
    legal   = acc & ~illegal;
    n       = legal ? 3 + dly : 1;
    WB_in = wb; MEM_in = mem; add_in = add; alu_in = alu; RD2_in = rd2; WN_in = wn; z_in = z;
    for (int unsigned c = 0; c < n; c++) begin
      dmi.dm_ack   = (legal && c == 1 + dly) || (spur && (c == 0 || c == n - 1));
      dmi.dm_rdata = (legal && c == 1 + dly) ? rdata : $urandom;
      @(negedge clk);
      req_exp = legal && c >= 1 && c <= 1 + dly;
      chk("stall", stall, legal && c < n - 1);
      chk("dm_req", dmi.dm_req, req_exp);
      if (req_exp) begin
        chk("dm_we", dmi.dm_we, wr);
        chk("dm_addr", dmi.dm_addr, alu);
        chk("dm_wdata", dmi.dm_wdata, rd2);
      end
      chk("pc_src", pc_src, (c == 0) && mem[2] && z);
      chk("br_target", br_target, add);
      @(posedge clk); #1;
      if (c == n - 1) begin
        if (illegal) begin
          m_err = 1'b1;
          m_wb  = '0;
        end else begin
          m_wb    = wb;
          m_rdata = (legal && rd) ? rdata : '0;
          m_alu   = alu;
          m_wn    = wn;
        end
      end else begin
        m_wb = '0;
      end
      chk("WB_out", WB_out, m_wb);
      chk("rdata_out", rdata_out, m_rdata);
      chk("alu_out", alu_out, m_alu);
      chk("WN_out", WN_out, m_wn);
      chk("err", err, m_err);
    end
    dmi.dm_ack = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] add, alu, rd2;
    logic [4:0]  wn;
    logic        z;
    int unsigned dly;
    logic [31:0] rdata;
    logic [1:0]  e_wb;
    logic [31:0] e_rdata, e_alu;
    logic [4:0]  e_wn;
    logic        e_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{2'b10, 3'b000, 32'h0,  32'h1234, 32'h0,    5'd7, 1'b0, 0, 32'h0,        2'b10, 32'h0,        32'h1234, 5'd7, 1'b0};
    tbl[1] = '{2'b11, 3'b010, 32'h0,  32'h100,  32'h0,    5'd3, 1'b0, 0, 32'hDEADBEEF, 2'b11, 32'hDEADBEEF, 32'h100,  5'd3, 1'b0};
    tbl[2] = '{2'b00, 3'b001, 32'h0,  32'h200,  32'hCAFE, 5'd4, 1'b0, 3, 32'h5555AAAA, 2'b00, 32'h0,        32'h200,  5'd4, 1'b0};
    tbl[3] = '{2'b11, 3'b010, 32'h0,  32'h102,  32'h0,    5'd9, 1'b0, 0, 32'h0,        2'b00, 32'h0,        32'h200,  5'd4, 1'b1};
    tbl[4] = '{2'b10, 3'b000, 32'h0,  32'h55,   32'h0,    5'd8, 1'b0, 0, 32'h0,        2'b10, 32'h0,        32'h55,   5'd8, 1'b1};
    tbl[5] = '{2'b00, 3'b100, 32'h40, 32'h0,    32'h0,    5'd0, 1'b1, 0, 32'h0,        2'b00, 32'h0,        32'h0,    5'd0, 1'b1};
    tbl[6] = '{2'b00, 3'b100, 32'h40, 32'h0,    32'h0,    5'd0, 1'b0, 0, 32'h0,        2'b00, 32'h0,        32'h0,    5'd0, 1'b1};

    rst = 1'b0;
    WB_in = '0; MEM_in = '0; add_in = '0; alu_in = '0; RD2_in = '0; WN_in = '0; z_in = 1'b0;
    dmi.dm_ack = 1'b0; dmi.dm_rdata = '0;
    model_reset();
    #12;
    chk("rst_dm_req", dmi.dm_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_WB_out", WB_out, 2'b00);
    chk("rst_rdata_out", rdata_out, 32'h0);
    chk("rst_alu_out", alu_out, 32'h0);
    chk("rst_WN_out", WN_out, 5'd0);
    chk("rst_err", err, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_instr(tbl[i].wb, tbl[i].mem, tbl[i].add, tbl[i].alu, tbl[i].rd2, tbl[i].wn,
                tbl[i].z, tbl[i].dly, tbl[i].rdata, 1'b0);
      chk($sformatf("tbl%0d_WB_out", i), WB_out, tbl[i].e_wb);
      chk($sformatf("tbl%0d_rdata_out", i), rdata_out, tbl[i].e_rdata);
      chk($sformatf("tbl%0d_alu_out", i), alu_out, tbl[i].e_alu);
      chk($sformatf("tbl%0d_WN_out", i), WN_out, tbl[i].e_wn);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
    end

    // Reset asserted while an access is in flight
    WB_in = 2'b11; MEM_in = 3'b010; alu_in = 32'h300; WN_in = 5'd12; dmi.dm_ack = 1'b0;
    @(posedge clk); #1;
    chk("mid_dm_req", dmi.dm_req, 1'b1);
    chk("mid_stall", stall, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_dm_req", dmi.dm_req, 1'b0);
    chk("arst_stall", stall, 1'b0);
    chk("arst_WB_out", WB_out, 2'b00);
    chk("arst_rdata_out", rdata_out, 32'h0);
    chk("arst_alu_out", alu_out, 32'h0);
    chk("arst_WN_out", WN_out, 5'd0);
    chk("arst_err", err, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1; MEM_in = 3'b000; WB_in = 2'b00; alu_in = '0; WN_in = '0;
    dmi.dm_ack = 1'b1; dmi.dm_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmi.dm_ack = 1'b0;
    chk("post_rst_dm_req", dmi.dm_req, 1'b0);
    chk("post_rst_rdata", rdata_out, 32'h0);
    run_instr(2'b10, 3'b000, 32'h0, 32'h77, 32'h0, 5'd2, 1'b0, 0, 32'h0, 1'b1);
    run_instr(2'b11, 3'b011, 32'h0, 32'h400, 32'h0, 5'd5, 1'b0, 0, 32'h0, 1'b0);
    chk("both_rw_err", err, 1'b1);

    for (int k = 0; k < 300; k++) begin
      logic [2:0]  mem;
      logic [31:0] alu;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      mem = (sel <= 3) ? 3'b000 : (sel <= 5) ? 3'b010 : (sel <= 7) ? 3'b001 : (sel == 8) ? 3'b100 : 3'b011;
      alu = $urandom;
      if ($urandom_range(0, 4) != 0) alu[1:0] = 2'b00;
      run_instr(2'($urandom), mem, $urandom, alu, $urandom, 5'($urandom), 1'($urandom),
                $urandom_range(0, 4), $urandom, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
